// File: rtl/sync_debounce.sv
// Purpose: per-channel synchronizer plus debouncer with registered edge pulses.
// Latency: an input step appears on out STAGES+DB_CYCLES-1 edges after the first edge that samples it.
// Backpressure: none; free-running, every channel updates every cycle.
module sync_debounce #(
  parameter int               WIDTH     = 4,
  parameter int               STAGES    = 2,
  parameter int               DB_CYCLES = 4,
  parameter logic [WIDTH-1:0] INIT      = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  // Counter only has to reach DB_CYCLES-1, so this width never wraps.
  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  // Reject configurations that cannot synchronize or qualify anything.
  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("sync_debounce: WIDTH must be in 1..32");
    end
    if (STAGES < 2) begin : g_bad_stages
      $error("sync_debounce: STAGES must be >= 2");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
      $error("sync_debounce: DB_CYCLES must be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_nxt[WIDTH];
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] accept;

  assign sync = sync_q[STAGES-1];
  assign diff = sync ^ out;

  // Metastability chain: stage 0 samples the raw pins, last stage feeds the debouncer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) sync_q[s] <= INIT;
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Qualification: count mismatching cycles, accept on the DB_CYCLES-th, restart on any agreement.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (diff[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          accept[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Counter state; reset discards any partial qualification.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_nxt[i];
    end
  end

  // Level and edge pulses are registered together so pulses line up with the new out value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out     <= INIT;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      out     <= out ^ accept;
      rise    <= accept & sync;
      fall    <= accept & ~sync;
      changed <= |accept;
    end
  end

endmodule
